// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the memory-access sequencer state type.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } mac_state_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: runs one load/store on a synchronous RAM port for a
// fixed number of wait cycles, holds the last loaded word and pulses done.
module mem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int          ADDR_W      = cpu_pkg::ADDR_W,
  parameter int          DATA_W      = cpu_pkg::DATA_W,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be at least 1");
  end

  mac_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CW'(WAIT_CYCLES - 1);
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // Read data is only guaranteed valid in the final access cycle.
          if (r_cnt == '0) begin
            if (!r_we) r_rdata <= mem_rdata;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = (r_state == ACCESS) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand sequences
// for back-to-back and WAIT_CYCLES=1 timing, and randomized traffic vs a model.
module tb_mem_access_ctrl;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        busy, done, mem_en, mem_we;
  logic [15:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic        req1, we1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;
  logic        busy1, done1, mem_en1, mem_we1;
  logic [15:0] rdata1, mem_wdata1, mem_rdata1;
  logic [7:0]  mem_addr1;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h01:   return 16'h1111;
      8'h02:   return 16'h2222;
      8'h30:   return 16'h3030;
      default: return {a, ~a};
    endcase
  endfunction

  // RAM environment: read data is valid only in the last cycle of an access.
  logic [15:0] ram [256];
  bit          ram_v [256];
  int          env_cnt = 0;

  always @(posedge clk) begin
    env_cnt <= mem_en ? env_cnt + 1 : 0;
    if (mem_en && mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      ram_v[mem_addr] <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = 16'hA5A5;
    if (mem_en && env_cnt == W - 1)
      mem_rdata = ram_v[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  assign mem_rdata1 = mem_en1 ? {mem_addr1, ~mem_addr1} : 16'hA5A5;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, req, we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy, done, en, mwe;
    logic [7:0]  maddr;
    logic [15:0] mwdata, rdata;
  } vec_t;

  function automatic vec_t mk(input logic r, q, w, input logic [7:0] a, input logic [15:0] wd,
                              input logic b, d, e, mw, input logic [7:0] ma,
                              input logic [15:0] mwd, rd);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd;
    v.busy = b; v.done = d; v.en = e; v.mwe = mw; v.maddr = ma; v.mwdata = mwd; v.rdata = rd;
    return v;
  endfunction

  function automatic logic [63:0] pack_out();
    return {20'h0, busy, done, mem_en, mem_we, mem_addr, mem_wdata, rdata};
  endfunction

  // Reference model: phase = cycles since acceptance (-1 when idle).
  int          m_phase;
  logic        m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [15:0] m_ram [256];
  bit          m_v [256];

  task automatic model_edge(input logic r, q, w, input logic [7:0] a, input logic [15:0] wd);
    if (m_phase >= 0 && m_phase < W && m_we) begin
      m_ram[m_addr] = m_wdata;
      m_v[m_addr]   = 1'b1;
    end
    if (r) begin
      m_phase = -1; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_phase < 0) begin
      if (q) begin
        m_phase = 0; m_we = w; m_addr = a; m_wdata = wd;
      end
    end else begin
      m_phase++;
      if (m_phase == W && !m_we) m_rdata = m_v[m_addr] ? m_ram[m_addr] : init_val(m_addr);
      if (m_phase == W + 1) m_phase = -1;
    end
  endtask

  function automatic logic [63:0] model_out();
    logic b, d, e, mw;
    b  = (m_phase >= 0);
    e  = (m_phase >= 0 && m_phase < W);
    d  = (m_phase == W);
    mw = e && m_we;
    return {20'h0, b, d, e, mw, m_addr, m_wdata, m_rdata};
  endfunction

  vec_t tbl [21];
  int   d_cyc [$];
  logic [15:0] d_dat [$];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    tbl[0]  = mk(1,0,0,8'h00,16'h0000, 0,0,0,0,8'h00,16'h0000,16'h0000);
    tbl[1]  = mk(0,1,0,8'h10,16'h0000, 1,0,1,0,8'h10,16'h0000,16'h0000);
    tbl[2]  = mk(0,0,0,8'h10,16'h0000, 1,0,1,0,8'h10,16'h0000,16'h0000);
    tbl[3]  = mk(0,0,0,8'h10,16'h0000, 1,1,0,0,8'h10,16'h0000,16'hBEEF);
    tbl[4]  = mk(0,0,0,8'h10,16'h0000, 0,0,0,0,8'h10,16'h0000,16'hBEEF);
    tbl[5]  = mk(0,1,1,8'h22,16'h1234, 1,0,1,1,8'h22,16'h1234,16'hBEEF);
    tbl[6]  = mk(0,0,1,8'h22,16'h1234, 1,0,1,1,8'h22,16'h1234,16'hBEEF);
    tbl[7]  = mk(0,0,1,8'h22,16'h1234, 1,1,0,0,8'h22,16'h1234,16'hBEEF);
    tbl[8]  = mk(0,0,0,8'h22,16'h1234, 0,0,0,0,8'h22,16'h1234,16'hBEEF);
    tbl[9]  = mk(0,1,0,8'h10,16'h0000, 1,0,1,0,8'h10,16'h0000,16'hBEEF);
    tbl[10] = mk(0,1,0,8'h30,16'h0000, 1,0,1,0,8'h10,16'h0000,16'hBEEF);
    tbl[11] = mk(0,1,0,8'h30,16'h0000, 1,1,0,0,8'h10,16'h0000,16'hBEEF);
    tbl[12] = mk(0,0,0,8'h30,16'h0000, 0,0,0,0,8'h10,16'h0000,16'hBEEF);
    tbl[13] = mk(0,0,0,8'h30,16'h0000, 0,0,0,0,8'h10,16'h0000,16'hBEEF);
    tbl[14] = mk(0,1,0,8'h01,16'h0000, 1,0,1,0,8'h01,16'h0000,16'hBEEF);
    tbl[15] = mk(1,1,0,8'h01,16'h0000, 0,0,0,0,8'h00,16'h0000,16'h0000);
    tbl[16] = mk(0,0,0,8'h02,16'h0000, 0,0,0,0,8'h00,16'h0000,16'h0000);
    tbl[17] = mk(0,1,0,8'h02,16'h0000, 1,0,1,0,8'h02,16'h0000,16'h0000);
    tbl[18] = mk(0,0,0,8'h02,16'h0000, 1,0,1,0,8'h02,16'h0000,16'h0000);
    tbl[19] = mk(0,0,0,8'h02,16'h0000, 1,1,0,0,8'h02,16'h0000,16'h2222);
    tbl[20] = mk(0,0,0,8'h02,16'h0000, 0,0,0,0,8'h02,16'h0000,16'h2222);

    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we;
      addr = tbl[i].addr; wdata = tbl[i].wdata;
      step();
      check($sformatf("vec%0d {busy,done,en,we,addr,wdata,rdata}", i), pack_out(),
            {20'h0, tbl[i].busy, tbl[i].done, tbl[i].en, tbl[i].mwe,
             tbl[i].maddr, tbl[i].mwdata, tbl[i].rdata});
    end
    req = 1'b0;
    check("ram22_after_store", {48'h0, ram[8'h22]}, 64'h1234);

    // Back-to-back loads with req held high.
    for (int i = 0; i < 12; i++) begin
      req = (i <= 4); we = 1'b0; addr = (i == 0) ? 8'h01 : 8'h02;
      step();
      if (done) begin
        d_cyc.push_back(i);
        d_dat.push_back(rdata);
      end
    end
    req = 1'b0;
    check("b2b_done_count", 64'(d_cyc.size()), 64'd2);
    if (d_cyc.size() == 2) begin
      check("b2b_spacing", 64'(d_cyc[1] - d_cyc[0]), 64'd4);
      check("b2b_rdata0", {48'h0, d_dat[0]}, 64'h1111);
      check("b2b_rdata1", {48'h0, d_dat[1]}, 64'h2222);
    end

    // WAIT_CYCLES=1 instance.
    req1 = 1'b1; addr1 = 8'h5A;
    step();
    req1 = 1'b0;
    check("w1_accept {busy,en,done}", {61'h0, busy1, mem_en1, done1}, 64'b110);
    step();
    check("w1_done {busy,en,done}", {61'h0, busy1, mem_en1, done1}, 64'b101);
    check("w1_rdata", {48'h0, rdata1}, 64'h5AA5);
    step();
    check("w1_idle {busy,en,done}", {61'h0, busy1, mem_en1, done1}, 64'b000);
    d_cyc.delete();
    for (int i = 0; i < 9; i++) begin
      req1 = (i < 7); addr1 = 8'(i);
      step();
      if (done1) d_cyc.push_back(i);
    end
    req1 = 1'b0;
    check("w1_done_count", 64'(d_cyc.size()), 64'd3);
    if (d_cyc.size() >= 2) check("w1_spacing", 64'(d_cyc[1] - d_cyc[0]), 64'd3);

    // Randomized traffic against the model.
    m_phase = -1;
    rst = 1'b1; req = 1'b0;
    step();
    model_edge(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    check("rand_reset", pack_out(), model_out());
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      req   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom_range(0, 1));
      addr  = 8'h40 + 8'($urandom_range(0, 15));
      wdata = 16'($urandom);
      step();
      model_edge(rst, req, we, addr, wdata);
      check($sformatf("rand%0d {busy,done,en,we,addr,wdata,rdata}", i), pack_out(), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-access sequencer between the control unit and the 16-bit data register. It accepts one load/store request at a time and drives a synchronous RAM port for a fixed number of wait cycles. On a load, it captures the RAM read data and holds it on `rdata`, which feeds the data register input directly. It reports completion with a one-cycle `done` pulse.

## Interface
- `ADDR_W`, 8, RAM address width.
- `DATA_W`, 16, data width; matches the data register.
- `WAIT_CYCLES`, 2, RAM access latency in cycles; must be ≥1; 0 is an elaboration error.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset, synchronous, active-high.
- `req`  in  1  Access request; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load; sampled with `req`.
- `addr`  in  `ADDR_W`  Access address; sampled with `req`.
- `wdata`  in  `DATA_W`  Store data; sampled with `req`.
- `busy`  out  1  High in ACCESS and DONE.
- `done`  out  1  One-cycle completion pulse.
- `rdata`  out  `DATA_W`  Last loaded word; held until the next load completes.
- `mem_en`  out  1  RAM enable.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  `ADDR_W`  RAM address.
- `mem_wdata`  out  `DATA_W`  RAM write data.
- `mem_rdata`  in  `DATA_W`  RAM read data; valid in the last ACCESS cycle.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:**
  - `req=1` at an edge latches `we`, `addr`, `wdata`.
  - Loads wait counter with `WAIT_CYCLES-1` and moves to ACCESS.
  - `req=0` stays in IDLE.
- **ACCESS:**
  - `mem_en=1`.
  - `mem_we` = latched `we`; `mem_addr` and `mem_wdata` = latched values, stable for the whole access.
  - Counter decrements each cycle.
  - At the edge where the counter is 0:
    - Load: `rdata <= mem_rdata`.
    - Go to DONE.
- **DONE:** `done=1`, `mem_en=0`, `mem_we=0`; next edge goes to IDLE unconditionally.
- Outside ACCESS: `mem_en=0`, `mem_we=0`; `mem_addr` and `mem_wdata` hold their last latched values.
- A store never modifies `rdata`.
- `req`, `we`, `addr`, `wdata` are ignored while `busy=1`; there is no queuing.
- `req` held high continuously produces back-to-back accesses, each starting on return to IDLE.

## Timing
- Request accepted at edge E0.
  - `mem_en` high from E0 to E0+`WAIT_CYCLES`.
  - `rdata` updates at E0+`WAIT_CYCLES`.
  - `done` high from E0+`WAIT_CYCLES` to E0+`WAIT_CYCLES`+1.
  - IDLE at E0+`WAIT_CYCLES`+1.
- Minimum request-to-request spacing: `WAIT_CYCLES`+2 cycles.
- `done` and the new `rdata` are visible in the same cycle, so the data register captures the correct word on the edge that ends DONE.
- Reset:
  - State goes to IDLE; counter, latched address/data, `rdata`, and all outputs go to 0.
  - Takes effect at the first edge with `rst=1`.
- Reset mid-access aborts the access: `mem_en` low after that edge, no `done`, `rdata` cleared.
- `req=1` together with `rst=1` is ignored.
- No combinational path from `req` to any output; every output is a register or decoded from state.

## Structure
- Shared package `cpu_pkg`: `mac_state_t` enum (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10), `DATA_W`=16, `ADDR_W`=8.
- Single module; the wait counter is inline, width `$clog2(WAIT_CYCLES+1)`. No sub-module.

## Test plan
- Load, `WAIT_CYCLES=2`: `addr=8'h10` with RAM[10]=16'hBEEF, `req` for 1 cycle -> `mem_en` high 2 cycles; `done` pulses 2 cycles after acceptance with `rdata=16'hBEEF`; `busy` high 3 cycles.
- Store: `we=1`, `addr=8'h22`, `wdata=16'h1234` -> `mem_we`/`mem_en` high 2 cycles with stable address/data; RAM[22]=16'h1234 afterwards; `rdata` unchanged.
- Busy drop: second `req` (`addr=8'h30`) asserted during ACCESS and deasserted before IDLE -> ignored; only one `done`; `mem_addr` stays 8'h10.
- Back-to-back: `req` held high for loads of 8'h01 then 8'h02 -> `done` pulses exactly 4 cycles apart; `rdata` shows RAM[01], then RAM[02].
- Reset mid-access: `rst` asserted in the first ACCESS cycle -> next cycle `mem_en=0`, `busy=0`, `rdata=0`, no `done`; a new load afterwards completes normally.
- `WAIT_CYCLES=1` build: load completes with `done` 1 cycle after acceptance; spacing 3 cycles.
